nmr_pulse_timer: RTL and testbench

// Executes one timing command at a time from the NMR bitstream command sequencer.
// On a BT_START strobe it latches [initial delay, pulse length, post-pulse delay].
// It then drives PLS_OUT high for exactly the pulse length, framed by the two delays in CLK cycles.
// BT_DONE is a ready level that the sequencer polls before issuing the next command.

---
 rtl/nmr_pulse_timer.sv | 189 ++++++++++++++++++
 tb/tb_nmr_pulse_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nmr_pulse_timer.sv
// Single-command NMR pulse timer: initial delay, gated pulse and post-pulse delay,
// with ready level, sticky overrun flag and completed-command counter.
module nmr_pulse_timer #(
    parameter int IDLY_WIDTH = 32,
    parameter int PLS_WIDTH  = 32,
    parameter int EDLY_WIDTH = 32,
    parameter int PCNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BT_START,
    input  logic [IDLY_WIDTH-1:0] idly_reg,
    input  logic [PLS_WIDTH-1:0]  pls_reg,
    input  logic [EDLY_WIDTH-1:0] edly_reg,
    input  logic                  CLR,
    output logic                  BT_DONE,
    output logic                  PLS_OUT,
    output logic                  OVERRUN,
    output logic [PCNT_WIDTH-1:0] PCNT
);

    localparam int CNT_IP = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
    localparam int CNT_W  = (CNT_IP > EDLY_WIDTH) ? CNT_IP : EDLY_WIDTH;
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PCNT_WIDTH-1:0] PCNT_ONE = {{(PCNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_IDLY = 3'd2,
        ST_PLS  = 3'd3,
        ST_EDLY = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        ph_cnt_r;
    logic [IDLY_WIDTH-1:0]   idly_r;
    logic [PLS_WIDTH-1:0]    pls_r;
    logic [EDLY_WIDTH-1:0]   edly_r;
    logic                    bt_done_r;
    logic                    pls_out_r;
    logic                    overrun_r;
    logic [PCNT_WIDTH-1:0]   pcnt_r;

    logic                    idly_nz_s;
    logic                    pls_nz_s;
    logic                    edly_nz_s;
    logic                    step_s;
    logic                    finish_s;
    state_t                  adv_state_s;
    logic [CNT_W-1:0]        adv_cnt_s;

    assign BT_DONE = bt_done_r;
    assign PLS_OUT = pls_out_r;
    assign OVERRUN = overrun_r;
    assign PCNT    = pcnt_r;

    assign idly_nz_s = (idly_r != {IDLY_WIDTH{1'b0}});
    assign pls_nz_s  = (pls_r  != {PLS_WIDTH{1'b0}});
    assign edly_nz_s = (edly_r != {EDLY_WIDTH{1'b0}});

    // Select the next nonzero phase after the current one; zero-length phases are skipped.
    always_comb begin
        adv_state_s = ST_IDLE;
        adv_cnt_s   = {CNT_W{1'b0}};
        case (state_r)
            ST_LOAD: begin
                if (idly_nz_s) begin
                    adv_state_s = ST_IDLY;
                    adv_cnt_s   = CNT_W'(idly_r);
                end else if (pls_nz_s) begin
                    adv_state_s = ST_PLS;
                    adv_cnt_s   = CNT_W'(pls_r);
                end else if (edly_nz_s) begin
                    adv_state_s = ST_EDLY;
                    adv_cnt_s   = CNT_W'(edly_r);
                end else begin
                    adv_state_s = ST_IDLE;
                    adv_cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_IDLY: begin
                if (pls_nz_s) begin
                    adv_state_s = ST_PLS;
                    adv_cnt_s   = CNT_W'(pls_r);
                end else if (edly_nz_s) begin
                    adv_state_s = ST_EDLY;
                    adv_cnt_s   = CNT_W'(edly_r);
                end else begin
                    adv_state_s = ST_IDLE;
                    adv_cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_PLS: begin
                if (edly_nz_s) begin
                    adv_state_s = ST_EDLY;
                    adv_cnt_s   = CNT_W'(edly_r);
                end else begin
                    adv_state_s = ST_IDLE;
                    adv_cnt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                adv_state_s = ST_IDLE;
                adv_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // A step happens when LOAD resolves or a running phase reaches its last cycle.
    always_comb begin
        step_s = 1'b0;
        case (state_r)
            ST_LOAD: step_s = 1'b1;
            ST_IDLY,
            ST_PLS,
            ST_EDLY: step_s = (ph_cnt_r == CNT_ONE);
            default: step_s = 1'b0;
        endcase
        finish_s = step_s && (adv_state_s == ST_IDLE);
    end

    // Command FSM with registered ready, pulse gate, overrun flag and completion counter.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            ph_cnt_r  <= {CNT_W{1'b0}};
            idly_r    <= {IDLY_WIDTH{1'b0}};
            pls_r     <= {PLS_WIDTH{1'b0}};
            edly_r    <= {EDLY_WIDTH{1'b0}};
            bt_done_r <= 1'b1;
            pls_out_r <= 1'b0;
            overrun_r <= 1'b0;
            pcnt_r    <= {PCNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (BT_START) begin
                        idly_r    <= idly_reg;
                        pls_r     <= pls_reg;
                        edly_r    <= edly_reg;
                        bt_done_r <= 1'b0;
                        state_r   <= ST_LOAD;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LOAD,
                ST_IDLY,
                ST_PLS,
                ST_EDLY: begin
                    if (step_s) begin
                        state_r   <= adv_state_s;
                        ph_cnt_r  <= adv_cnt_s;
                        // Gate follows the phase being entered, so no gap or glitch between phases.
                        pls_out_r <= (adv_state_s == ST_PLS);
                        bt_done_r <= finish_s;
                    end else begin
                        ph_cnt_r  <= ph_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    ph_cnt_r  <= {CNT_W{1'b0}};
                    bt_done_r <= 1'b1;
                    pls_out_r <= 1'b0;
                end
            endcase

            // A new overrun wins over a simultaneous clear.
            if (BT_START && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else if (CLR) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            if (CLR) begin
                pcnt_r <= {PCNT_WIDTH{1'b0}};
            end else if (finish_s) begin
                pcnt_r <= pcnt_r + PCNT_ONE;
            end else begin
                pcnt_r <= pcnt_r;
            end
        end
    end

endmodule

// File: tb/tb_nmr_pulse_timer.sv
// Self-checking bench for nmr_pulse_timer: table of commands with hand-derived timing,
// plus overrun/clear and mid-pulse reset sequences, checked through an expectation queue.
module tb_nmr_pulse_timer;

    localparam int PW = 3;

    logic          CLK;
    logic          RST;
    logic          BT_START;
    logic [31:0]   idly_reg;
    logic [31:0]   pls_reg;
    logic [7:0]    edly_reg;
    logic          CLR;
    logic          BT_DONE;
    logic          PLS_OUT;
    logic          OVERRUN;
    logic [PW-1:0] PCNT;

    nmr_pulse_timer #(
        .IDLY_WIDTH(32), .PLS_WIDTH(32), .EDLY_WIDTH(8), .PCNT_WIDTH(PW)
    ) dut (
        .CLK(CLK), .RST(RST), .BT_START(BT_START),
        .idly_reg(idly_reg), .pls_reg(pls_reg), .edly_reg(edly_reg),
        .CLR(CLR), .BT_DONE(BT_DONE), .PLS_OUT(PLS_OUT),
        .OVERRUN(OVERRUN), .PCNT(PCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int idly;
        int pls;
        int edly;
        int busy;   // cycles with BT_DONE low
        int first;  // sample index of first PLS_OUT high, -1 if none
    } vec_t;

    typedef struct {
        int busy;
        int high;
        int rises;
        int first;
        int pcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pcnt_model = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one command, observe it to completion, then compare against the queued expectation.
    task automatic run_cmd(input int i, input int p, input int e, input exp_t ex,
                           input int inj, input int rst_at, input string tag);
        int   n;
        int   busy;
        int   high;
        int   rises;
        int   first;
        bit   prev;
        bit   done;
        exp_t got;
        exp_t want;
        exp_q.push_back(ex);
        @(negedge CLK);
        BT_START = 1'b1;
        idly_reg = i;
        pls_reg  = p;
        edly_reg = e[7:0];
        @(posedge CLK);
        #1;
        BT_START = 1'b0;
        idly_reg = $urandom_range(1, 50);
        pls_reg  = $urandom_range(1, 50);
        edly_reg = 8'($urandom_range(1, 50));
        n = 0; busy = 0; high = 0; rises = 0; first = -1; prev = 1'b0; done = 1'b0;
        while (!done && n < 300) begin
            @(negedge CLK);
            if (BT_DONE) done = 1'b1;
            else busy++;
            if (PLS_OUT) begin
                high++;
                if (!prev) begin
                    rises++;
                    if (first < 0) first = n;
                end
            end
            prev = PLS_OUT;
            if (!done) begin
                if (n == inj) begin
                    BT_START = 1'b1;
                    idly_reg = 32'd7;
                    pls_reg  = 32'd7;
                    edly_reg = 8'd7;
                end
                if (n == rst_at) RST = 1'b0;
                @(posedge CLK);
                #1;
                BT_START = 1'b0;
                RST      = 1'b1;
            end
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: BT_DONE still %0d after %0d cycles", tag, BT_DONE, n);
        end
        got.busy = busy; got.high = high; got.rises = rises; got.first = first; got.pcnt = int'(PCNT);
        want = exp_q.pop_front();
        check({tag, " busy"},  got.busy,  want.busy);
        check({tag, " high"},  got.high,  want.high);
        check({tag, " rises"}, got.rises, want.rises);
        check({tag, " first"}, got.first, want.first);
        check({tag, " pcnt"},  got.pcnt,  want.pcnt);
    endtask

    initial begin
        vec_t tbl[8];
        exp_t ex;
        tbl[0] = '{idly: 3, pls: 5, edly: 2, busy: 11, first: 4};
        tbl[1] = '{idly: 0, pls: 1, edly: 0, busy: 2,  first: 1};
        tbl[2] = '{idly: 0, pls: 0, edly: 0, busy: 1,  first: -1};
        tbl[3] = '{idly: 2, pls: 0, edly: 3, busy: 6,  first: -1};
        tbl[4] = '{idly: 1, pls: 2, edly: 1, busy: 5,  first: 2};
        tbl[5] = '{idly: 0, pls: 0, edly: 4, busy: 5,  first: -1};
        tbl[6] = '{idly: 4, pls: 3, edly: 0, busy: 8,  first: 5};
        tbl[7] = '{idly: 0, pls: 2, edly: 0, busy: 3,  first: 1};

        RST = 1'b0; BT_START = 1'b0; CLR = 1'b0;
        idly_reg = 32'd0; pls_reg = 32'd0; edly_reg = 8'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("reset BT_DONE", int'(BT_DONE), 1);
        check("reset PLS_OUT", int'(PLS_OUT), 0);
        check("reset OVERRUN", int'(OVERRUN), 0);
        check("reset PCNT",    int'(PCNT),    0);

        // Eight commands on a 3-bit counter also cover the wrap from 7 back to 0.
        for (int k = 0; k < 8; k++) begin
            pcnt_model = (pcnt_model + 1) % (1 << PW);
            ex.busy  = tbl[k].busy;
            ex.high  = tbl[k].pls;
            ex.rises = (tbl[k].pls > 0) ? 1 : 0;
            ex.first = tbl[k].first;
            ex.pcnt  = pcnt_model;
            run_cmd(tbl[k].idly, tbl[k].pls, tbl[k].edly, ex, -1, -1, $sformatf("vec%0d", k));
        end
        check("OVERRUN idle after table", int'(OVERRUN), 0);

        // Second start four cycles into a 3/5/2 command must not disturb it.
        pcnt_model = (pcnt_model + 1) % (1 << PW);
        ex = '{busy: 11, high: 5, rises: 1, first: 4, pcnt: pcnt_model};
        run_cmd(3, 5, 2, ex, 3, -1, "overrun");
        check("OVERRUN set", int'(OVERRUN), 1);
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        pcnt_model = 0;
        @(negedge CLK);
        check("CLR OVERRUN", int'(OVERRUN), 0);
        check("CLR PCNT",    int'(PCNT),    pcnt_model);

        // Reset at edge k+7 while the pulse is high: 3 pulse samples seen, nothing counted.
        pcnt_model = 0;
        ex = '{busy: 7, high: 3, rises: 1, first: 4, pcnt: 0};
        run_cmd(3, 5, 2, ex, -1, 6, "rst_in_pls");
        check("rst PLS_OUT", int'(PLS_OUT), 0);

        pcnt_model = 1;
        ex = '{busy: 5, high: 2, rises: 1, first: 2, pcnt: pcnt_model};
        run_cmd(1, 2, 1, ex, -1, -1, "after_rst");

        check("queue drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
